// File: rtl/galaksija_tape_player_if.sv
// Byte read port between the tape player and the SDRAM tape buffer.
//   mem_rd   : one-cycle read request (player -> memory)
//   mem_addr : byte address, held while the request is outstanding
//   mem_ack  : one-cycle data-valid strobe (memory -> player)
//   mem_data : read data, valid with mem_ack
// master = tape player side, slave = memory side.
interface galaksija_tape_player_if #(
  parameter int ADDR_W = 14
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;

  modport master (output mem_rd, mem_addr, input mem_ack, mem_data);
  modport slave  (input mem_rd, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/galaksija_tape_player.sv
// Galaksija cassette playback sequencer.
// Fetches bytes 0..length from the tape buffer over the mem read port and
// plays each one LSB first as 8 bits x 8 sub-steps on tape_bit (low on
// sub-step 0, and on sub-step 4 for a '1' bit), followed by an idle-high
// gap. Play and gap timing advance only while throttle is high.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start, abort     : one-cycle commands (abort wins over start)
//   length           : index of last byte to play, sampled on start
//   throttle         : 1 = play/gap timers advance, 0 = they hold
//   mem              : byte read port (master side)
//   tape_bit         : serial tape level, idle high
//   busy             : playback in progress
//   byte_idx         : byte currently being played
//   done             : one-cycle pulse after the last byte's gap
//   err              : sticky fetch-timeout flag, cleared by start/reset
module galaksija_tape_player #(
  parameter int ADDR_W      = 14,
  parameter int STEP_CYCLES = 1151,
  parameter int GAP_CYCLES  = 13001,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     length,
  input  logic                  throttle,
  galaksija_tape_player_if.master mem,
  output logic                  tape_bit,
  output logic                  busy,
  output logic [ADDR_W-1:0]     byte_idx,
  output logic                  done,
  output logic                  err
);

  // One timer is shared by WAIT (ack timeout), PLAY (sub-step) and GAP.
  localparam int TMR_MAX0 = (GAP_CYCLES > STEP_CYCLES) ? GAP_CYCLES : STEP_CYCLES;
  localparam int TMR_MAX  = (TMR_MAX0 > ACK_TIMEOUT) ? TMR_MAX0 : ACK_TIMEOUT;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [5:0]        pos_q, pos_d;        // {bit index, sub-step}
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] length_q, length_d;
  logic              tape_q, tape_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [5:0]        pos_next;

  // Tape level for a given sub-step position of the current byte.
  function automatic logic sub_level(input logic [5:0] p, input logic [7:0] b);
    return !((p[2:0] == 3'd0) || ((p[2:0] == 3'd4) && b[p[5:3]]));
  endfunction

  assign pos_next = pos_q + 6'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pos_q      <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      length_q   <= '0;
      tape_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pos_q      <= pos_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      length_q   <= length_d;
      tape_q     <= tape_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pos_d      = pos_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    length_d   = length_q;
    tape_d     = tape_q;
    done_d     = 1'b0;
    err_d      = err_q;
    if (abort) begin
      state_d = S_IDLE;
      tape_d  = 1'b1;
    end else if (start) begin
      // Restart from byte 0 in any state; a pending ack is dropped because
      // WAIT is only reached again through a fresh FETCH.
      state_d    = S_FETCH;
      length_d   = length;
      byte_idx_d = '0;
      err_d      = 1'b0;
      tape_d     = 1'b1;
      timer_d    = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          state_d = S_WAIT;
          timer_d = '0;
        end
        S_WAIT: begin
          // Timeout runs on raw clock cycles, not throttled ones.
          if (mem.mem_ack || (timer_q == TMR_W'(ACK_TIMEOUT - 1))) begin
            shift_d = mem.mem_ack ? mem.mem_data : 8'hFF;
            err_d   = err_q | ~mem.mem_ack;
            state_d = S_PLAY;
            timer_d = '0;
            pos_d   = '0;
            tape_d  = 1'b0;   // sub-step 0 is always low
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_PLAY: begin
          if (throttle) begin
            if (timer_q == TMR_W'(STEP_CYCLES - 1)) begin
              timer_d = '0;
              if (pos_q == 6'd63) begin
                state_d = S_GAP;
                tape_d  = 1'b1;
              end else begin
                pos_d  = pos_next;
                tape_d = sub_level(pos_next, shift_q);
              end
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (throttle) begin
            if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
              timer_d = '0;
              if (byte_idx_q == length_q) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                byte_idx_d = byte_idx_q + 1'b1;
                state_d    = S_FETCH;
              end
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem.mem_rd   = (state_q == S_FETCH);
    mem.mem_addr = byte_idx_q;
    busy         = (state_q != S_IDLE);
    tape_bit     = tape_q;
    byte_idx     = byte_idx_q;
    done         = done_q;
    err          = err_q;
  end

endmodule
